// File: rtl/run_display_pkg.sv
// Shared types and constants for the run/halt display controller.
package run_display_pkg;

  // Controller phases: hold datapath in reset, run, confirm halt, show, give up.
  typedef enum logic [2:0] {
    BOOT,
    RUN,
    SETTLE,
    SHOW,
    FAULT
  } state_t;

  // Display page encodings; value 3 is never produced.
  localparam logic [1:0] PG_COORD = 2'd0;
  localparam logic [1:0] PG_SAD   = 2'd1;
  localparam logic [1:0] PG_PCWB  = 2'd2;

  // Right-hand display contents while faulted.
  localparam logic [15:0] FAULT_PATTERN = 16'hDEAD;

  // Page rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_page(input logic [1:0] pg);
    return (pg == PG_PCWB) ? PG_COORD : pg + 2'd1;
  endfunction

endpackage

// File: rtl/page_timer.sv
// Free-running cycle counter with synchronous clear and enable; emits a
// one-cycle tick on the last count of each CYCLES-long period.
module page_timer #(
  parameter int unsigned CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_reg;

  assign tick = en && !clr && (cnt_reg == LAST);

  // Count while enabled, restarting the period after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/run_display_ctrl.sv
// Sequences datapath reset release, detects the terminal halt loop, latches
// the results and rotates them across the two 4-digit displays.
module run_display_ctrl
  import run_display_pkg::*;
#(
  parameter logic [31:0] HALT_PC        = 32'h0000_01FC,
  parameter int unsigned BOOT_CYCLES    = 16,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter int unsigned PAGE_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_048_576
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Restart,
  input  logic [31:0] PCResult,
  input  logic [31:0] xCoord,
  input  logic [31:0] yCoord,
  input  logic [31:0] sad,
  input  logic [31:0] WritebackOutput,
  output logic        DpRun,
  output logic [15:0] DispLeft,
  output logic [15:0] DispRight,
  output logic [1:0]  Page,
  output logic        Done,
  output logic        Timeout
);

  localparam int unsigned STW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STW-1:0] STABLE_LAST = STW'(STABLE_CYCLES - 1);
  localparam logic [TOW-1:0] TMO_LAST    = TOW'(TIMEOUT_CYCLES - 1);

  state_t state_reg, state_next;
  logic [STW-1:0] stable_reg, stable_next;
  logic [TOW-1:0] tmo_reg, tmo_next;
  logic [1:0]  page_reg, page_next;
  logic        done_reg, done_next;
  logic        timeout_reg, timeout_next;
  logic        dp_run_reg;
  logic        latch_en;
  logic        halt_hit;
  logic        boot_tick, page_tick;
  logic [15:0] hold_x_reg, hold_y_reg, hold_pc_reg, hold_wb_reg;
  logic [31:0] hold_sad_reg;
  logic [15:0] left_next, right_next, left_reg, right_reg;

  // Upper halves of these buses are never displayed.
  logic unused_bits;
  assign unused_bits = ^{xCoord[31:16], yCoord[31:16], PCResult[31:16], WritebackOutput[31:16]};

  assign halt_hit = (PCResult == HALT_PC);

  page_timer #(.CYCLES(BOOT_CYCLES)) u_boot_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (Restart || (state_reg != BOOT)),
    .en    (state_reg == BOOT),
    .tick  (boot_tick)
  );

  page_timer #(.CYCLES(PAGE_CYCLES)) u_page_timer (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (Restart || (state_reg != SHOW)),
    .en    (state_reg == SHOW),
    .tick  (page_tick)
  );

  // Next-state logic; Restart overrides every other transition.
  always_comb begin
    state_next   = state_reg;
    stable_next  = stable_reg;
    tmo_next     = tmo_reg;
    page_next    = page_reg;
    done_next    = done_reg;
    timeout_next = timeout_reg;
    latch_en     = 1'b0;
    if (Restart) begin
      state_next   = BOOT;
      stable_next  = '0;
      tmo_next     = '0;
      page_next    = PG_COORD;
      done_next    = 1'b0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          if (boot_tick) begin
            state_next = RUN;
            tmo_next   = '0;
          end
        end
        RUN: begin
          if (tmo_reg == TMO_LAST) begin
            state_next   = FAULT;
            timeout_next = 1'b1;
          end else begin
            tmo_next = tmo_reg + TOW'(1);
            if (halt_hit) begin
              state_next  = SETTLE;
              stable_next = STW'(1);
            end
          end
        end
        SETTLE: begin
          // A confirmed halt wins over a coincident timeout.
          if (halt_hit && (stable_reg == STABLE_LAST)) begin
            state_next = SHOW;
            latch_en   = 1'b1;
            done_next  = 1'b1;
            page_next  = PG_COORD;
          end else if (tmo_reg == TMO_LAST) begin
            state_next   = FAULT;
            timeout_next = 1'b1;
          end else begin
            tmo_next = tmo_reg + TOW'(1);
            if (!halt_hit) begin
              state_next  = RUN;
              stable_next = '0;
            end else begin
              stable_next = stable_reg + STW'(1);
            end
          end
        end
        SHOW: begin
          if (page_tick) page_next = next_page(page_reg);
        end
        FAULT: ;
        default: state_next = BOOT;
      endcase
    end
  end

  // Control state registers; DpRun follows the state being entered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= BOOT;
      stable_reg  <= '0;
      tmo_reg     <= '0;
      page_reg    <= PG_COORD;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      dp_run_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      stable_reg  <= stable_next;
      tmo_reg     <= tmo_next;
      page_reg    <= page_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      dp_run_reg  <= (state_next != BOOT);
    end
  end

  // Result hold registers, captured on the confirming halt sample.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold_x_reg   <= '0;
      hold_y_reg   <= '0;
      hold_pc_reg  <= '0;
      hold_wb_reg  <= '0;
      hold_sad_reg <= '0;
    end else if (Restart) begin
      hold_x_reg   <= '0;
      hold_y_reg   <= '0;
      hold_pc_reg  <= '0;
      hold_wb_reg  <= '0;
      hold_sad_reg <= '0;
    end else if (latch_en) begin
      hold_x_reg   <= xCoord[15:0];
      hold_y_reg   <= yCoord[15:0];
      hold_pc_reg  <= PCResult[15:0];
      hold_wb_reg  <= WritebackOutput[15:0];
      hold_sad_reg <= sad;
    end
  end

  // Display source selection from the current state and page.
  always_comb begin
    left_next  = yCoord[15:0];
    right_next = xCoord[15:0];
    case (state_reg)
      SHOW: begin
        case (page_reg)
          PG_SAD: begin
            left_next  = hold_sad_reg[31:16];
            right_next = hold_sad_reg[15:0];
          end
          PG_PCWB: begin
            left_next  = hold_pc_reg;
            right_next = hold_wb_reg;
          end
          default: begin
            left_next  = hold_y_reg;
            right_next = hold_x_reg;
          end
        endcase
      end
      FAULT: begin
        left_next  = PCResult[15:0];
        right_next = FAULT_PATTERN;
      end
      default: ;
    endcase
  end

  // Display output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      left_reg  <= '0;
      right_reg <= '0;
    end else begin
      left_reg  <= left_next;
      right_reg <= right_next;
    end
  end

  assign DpRun     = dp_run_reg;
  assign DispLeft  = left_reg;
  assign DispRight = right_reg;
  assign Page      = page_reg;
  assign Done      = done_reg;
  assign Timeout   = timeout_reg;

endmodule

// File: tb/tb_run_display_ctrl.sv
// Scoreboard bench: expectations are queued against an edge number when the
// stimulus is driven and checked once the DUT has reached that edge.
module tb_run_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] pc = 32'h10, x = 32'd5, y = 32'd7, sad = 32'h0001_2345, wb = 32'hABCD_1234;
  logic        dp_run, done, timeout;
  logic [15:0] disp_left, disp_right;
  logic [1:0]  page;

  always #5 clk = ~clk;

  run_display_ctrl #(
    .HALT_PC        (32'h0000_01FC),
    .BOOT_CYCLES    (4),
    .STABLE_CYCLES  (3),
    .PAGE_CYCLES    (10),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .Clk             (clk),
    .Reset           (rst_n),
    .Restart         (restart),
    .PCResult        (pc),
    .xCoord          (x),
    .yCoord          (y),
    .sad             (sad),
    .WritebackOutput (wb),
    .DpRun           (dp_run),
    .DispLeft        (disp_left),
    .DispRight       (disp_right),
    .Page            (page),
    .Done            (done),
    .Timeout         (timeout)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  typedef enum int {S_DPRUN, S_DONE, S_TMO, S_PAGE, S_LEFT, S_RIGHT} sig_e;
  typedef struct {
    string       tag;
    int          at;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt;

  // Edges counted since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic void expect_at(input string tag, input int at, input sig_e s, input logic [31:0] v);
    exp_t e;
    int   i;
    e.tag = tag; e.at = at; e.sig = s; e.val = v;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endfunction

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_DPRUN: return 32'(dp_run);
      S_DONE:  return 32'(done);
      S_TMO:   return 32'(timeout);
      S_PAGE:  return 32'(page);
      S_LEFT:  return 32'(disp_left);
      default: return 32'(disp_right);
    endcase
  endfunction

  // Pop and compare every expectation due at the current edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
      e = sb.pop_front();
      check_val($sformatf("%s@%0d", e.tag, e.at), observe(e.sig), e.val);
    end
  end

  task automatic at_neg(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Pulse Restart for one edge; returns the edge count before the pulse.
  task automatic do_restart(output int b);
    b = edge_cnt;
    restart = 1'b1;
    pc = 32'h100;
    expect_at("rst_done",  b + 1, S_DONE,  0);
    expect_at("rst_dprun", b + 1, S_DPRUN, 0);
    expect_at("rst_page",  b + 1, S_PAGE,  0);
    expect_at("rst_tmo",   b + 1, S_TMO,   0);
    expect_at("boot_low",  b + 4, S_DPRUN, 0);
    expect_at("boot_rise", b + 5, S_DPRUN, 1);
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b;
    // Reset values while Reset is held low.
    #12;
    check_val("por_dprun", 32'(dp_run), 0);
    check_val("por_done",  32'(done), 0);
    check_val("por_tmo",   32'(timeout), 0);
    check_val("por_page",  32'(page), 0);
    check_val("por_left",  32'(disp_left), 0);
    check_val("por_right", 32'(disp_right), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: boot, run, halt detection.
    expect_at("t1_boot_low",  3, S_DPRUN, 0);
    expect_at("t1_boot_rise", 4, S_DPRUN, 1);
    expect_at("t1_live_l",    6, S_LEFT,  32'h7);
    expect_at("t1_live_r",    6, S_RIGHT, 32'h5);
    expect_at("t1_done_lo",  10, S_DONE,  0);
    expect_at("t1_done_hi",  11, S_DONE,  1);
    expect_at("t1_page0",    11, S_PAGE,  0);
    expect_at("t1_hold_l",   12, S_LEFT,  32'h7);
    expect_at("t1_hold_r",   12, S_RIGHT, 32'h5);
    at_neg(5); pc = 32'h20;
    at_neg(6); pc = 32'h30;
    at_neg(7); pc = 32'h40;
    at_neg(8); pc = 32'h1FC;
    at_neg(11); x = 32'h99; y = 32'h88; wb = 32'h5555;

    // 2: page rotation in SHOW.
    expect_at("t2_page_a",  20, S_PAGE,  0);
    expect_at("t2_page_b",  21, S_PAGE,  1);
    expect_at("t2_lag_l",   21, S_LEFT,  32'h7);
    expect_at("t2_sad_l",   22, S_LEFT,  32'h0001);
    expect_at("t2_sad_r",   22, S_RIGHT, 32'h2345);
    expect_at("t2_page_c",  30, S_PAGE,  1);
    expect_at("t2_page_d",  31, S_PAGE,  2);
    expect_at("t2_pc_l",    32, S_LEFT,  32'h01FC);
    expect_at("t2_wb_r",    32, S_RIGHT, 32'h1234);
    expect_at("t2_page_e",  41, S_PAGE,  0);
    expect_at("t2_dprun",   41, S_DPRUN, 1);
    expect_at("t2_done",    41, S_DONE,  1);
    expect_at("t2_wrap_l",  42, S_LEFT,  32'h7);
    expect_at("t2_wrap_r",  42, S_RIGHT, 32'h5);
    at_neg(43);

    // 3: interrupted halt visit returns to RUN.
    do_restart(b);
    at_neg(b + 5); pc = 32'h1FC;
    at_neg(b + 7); pc = 32'h200;
    at_neg(b + 8); pc = 32'h1FC;
    expect_at("t3_done_a", b + 9,  S_DONE, 0);
    expect_at("t3_done_b", b + 10, S_DONE, 0);
    expect_at("t3_done_c", b + 11, S_DONE, 1);
    at_neg(b + 12);

    // 5: Restart coinciding with the final stable sample.
    do_restart(b);
    at_neg(b + 5); pc = 32'h1FC;
    at_neg(b + 7); restart = 1'b1;
    expect_at("t5_done",    b + 8,  S_DONE,  0);
    expect_at("t5_dprun",   b + 8,  S_DPRUN, 0);
    expect_at("t5_page",    b + 8,  S_PAGE,  0);
    expect_at("t5_boot_lo", b + 11, S_DPRUN, 0);
    expect_at("t5_boot_hi", b + 12, S_DPRUN, 1);
    expect_at("t5_done_lo", b + 14, S_DONE,  0);
    expect_at("t5_done_hi", b + 15, S_DONE,  1);
    expect_at("t5_hold_l",  b + 16, S_LEFT,  32'h88);
    at_neg(b + 8); restart = 1'b0;
    at_neg(b + 17);

    // 4: timeout when the halt PC never appears.
    do_restart(b);
    expect_at("t4_tmo_lo",  b + 54, S_TMO,   0);
    expect_at("t4_tmo_hi",  b + 55, S_TMO,   1);
    expect_at("t4_dprun",   b + 55, S_DPRUN, 1);
    expect_at("t4_live_pc", b + 56, S_LEFT,  32'h4321);
    expect_at("t4_dead",    b + 56, S_RIGHT, 32'hDEAD);
    expect_at("t4_tmo_hold",b + 60, S_TMO,   1);
    expect_at("t4_no_done", b + 60, S_DONE,  0);
    at_neg(b + 55); pc = 32'h4321;
    at_neg(b + 61);

    // 6: asynchronous reset in SETTLE.
    do_restart(b);
    at_neg(b + 5); pc = 32'h1FC;
    at_neg(b + 6);
    #2;
    check_val("t6_pre_dprun", 32'(dp_run), 1);
    check_val("t6_pre_left",  32'(disp_left), 32'h88);
    rst_n = 1'b0;
    #1;
    check_val("t6_dprun", 32'(dp_run), 0);
    check_val("t6_done",  32'(done), 0);
    check_val("t6_tmo",   32'(timeout), 0);
    check_val("t6_page",  32'(page), 0);
    check_val("t6_left",  32'(disp_left), 0);
    check_val("t6_right", 32'(disp_right), 0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    expect_at("t6_boot_lo", 3, S_DPRUN, 0);
    expect_at("t6_boot_hi", 4, S_DPRUN, 1);
    at_neg(6);
    check_val("sb_drain", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
